// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART receiver: register map,
// STATUS bit positions, receiver FSM encoding and the minimum baud divisor.
package uart_pkg;

  localparam logic [3:0] RXDATA_OFS = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;
  localparam logic [3:0] BAUD_OFS   = 4'h8;
  localparam logic [3:0] CTRL_OFS   = 4'hC;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;

  localparam logic [15:0] MIN_BAUD = 16'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_periph_sync_fifo.sv
// Show-ahead synchronous FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate occupancy counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // A push into a full FIFO is accepted when a pop frees the head slot in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  // Pointer update; wrap-around comes for free from the extra MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage array, no reset needed: contents are only visible behind the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_periph.sv
// Memory-mapped 8N1 UART receiver: synchronizes the serial line, deframes
// characters with a programmable baud divisor, buffers them in a FIFO and
// exposes data/status/config registers with a one-cycle ready handshake.
module uart_rx_periph
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        ready,
  input  logic        uart_rx,
  output logic        rx_irq
);

  function automatic logic [15:0] clamp_baud(input logic [15:0] v);
    return (v < MIN_BAUD) ? MIN_BAUD : v;
  endfunction

  logic        sync1, sync2, prev;
  logic        fall;
  rx_state_t   state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shreg, shreg_n;
  logic        push_req;
  logic        frame_set;
  logic [15:0] baud;
  logic [15:0] half_m1;
  logic [15:0] full_m1;
  logic [1:0]  ctrl;
  logic        overrun, frame_err;
  logic        overrun_set;
  logic [3:0]  reg_ofs;
  logic        sel_rxdata, sel_status, sel_baud, sel_ctrl;
  logic        fifo_push, fifo_pop;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;
  logic [31:0] status_word;
  logic [31:0] read_word;
  logic        unused_bits;

  assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:16]};

  assign reg_ofs    = {addr[3:2], 2'b00};
  assign sel_rxdata = (reg_ofs == RXDATA_OFS);
  assign sel_status = (reg_ofs == STATUS_OFS);
  assign sel_baud   = (reg_ofs == BAUD_OFS);
  assign sel_ctrl   = (reg_ofs == CTRL_OFS);

  assign fall    = prev & ~sync2;
  assign half_m1 = {1'b0, baud[15:1]} - 16'd1;
  assign full_m1 = baud - 16'd1;

  // A pop that coincides with a completed stop bit makes room, so it is not an overrun.
  assign fifo_pop    = re & sel_rxdata & ~fifo_empty;
  assign fifo_push   = push_req & (~fifo_full | fifo_pop);
  assign overrun_set = push_req & fifo_full & ~fifo_pop;

  always_comb begin
    status_word               = '0;
    status_word[ST_NOT_EMPTY] = ~fifo_empty;
    status_word[ST_FULL]      = fifo_full;
    status_word[ST_OVERRUN]   = overrun;
    status_word[ST_FRAME_ERR] = frame_err;
  end

  // Read mux, sampled into rdata on the read strobe.
  always_comb begin
    read_word = '0;
    if (sel_rxdata)      read_word = fifo_empty ? 32'd0 : {24'd0, fifo_dout};
    else if (sel_status) read_word = status_word;
    else if (sel_baud)   read_word = {16'd0, baud};
    else if (sel_ctrl)   read_word = {30'd0, ctrl};
  end

  // Two-flop synchronizer plus a history flop for falling-edge detection; idle high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Receiver FSM control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
    end
  end

  // Shift register holds only payload bits, so it needs no reset.
  always_ff @(posedge clk) begin
    shreg <= shreg_n;
  end

  // Next-state logic: mid-bit sampling driven by the baud counter.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 16'd1;
    bit_n     = bit_idx;
    shreg_n   = shreg;
    push_req  = 1'b0;
    frame_set = 1'b0;
    if (!ctrl[0]) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_n = '0;
          if (fall) state_n = START;
        end
        START: begin
          if (cnt == half_m1) begin
            cnt_n = '0;
            if (!sync2) begin
              bit_n   = '0;
              state_n = DATA;
            end else begin
              state_n = IDLE;
            end
          end
        end
        DATA: begin
          if (cnt == full_m1) begin
            cnt_n   = '0;
            shreg_n = {sync2, shreg[7:1]};
            bit_n   = bit_idx + 3'd1;
            if (bit_idx == 3'd7) state_n = STOP;
          end
        end
        STOP: begin
          if (cnt == full_m1) begin
            cnt_n   = '0;
            state_n = IDLE;
            if (sync2) push_req  = 1'b1;
            else       frame_set = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Configuration and sticky error flags; a set in the same cycle beats W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud      <= 16'(CLKS_PER_BIT);
      ctrl      <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (we && sel_baud) baud <= clamp_baud(wdata[15:0]);
      if (we && sel_ctrl) ctrl <= wdata[1:0];
      overrun   <= overrun_set |
                   (overrun & ~(we & sel_status & wdata[ST_OVERRUN]));
      frame_err <= frame_set |
                   (frame_err & ~(we & sel_status & wdata[ST_FRAME_ERR]));
    end
  end

  // Bus response: single ready pulse per strobe, rdata held until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
      ready <= 1'b0;
    end else begin
      ready <= we | re;
      if (re) rdata <= read_word;
    end
  end

  // Registered level interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_irq <= 1'b0;
    else       rx_irq <= ctrl[1] & ~fifo_empty;
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (shreg),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_periph.sv
// Directed bench for uart_rx_periph with 16 clk/bit serial stimulus.
module tb_uart_rx_periph;

  localparam logic [31:0] A_RX   = 32'h0;
  localparam logic [31:0] A_ST   = 32'h4;
  localparam logic [31:0] A_BAUD = 32'h8;
  localparam logic [31:0] A_CTRL = 32'hC;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        ready;
  logic        uart_rx;
  logic        rx_irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] d;

  uart_rx_periph #(
    .CLKS_PER_BIT(16),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .wdata  (wdata),
    .we     (we),
    .re     (re),
    .rdata  (rdata),
    .ready  (ready),
    .uart_rx(uart_rx),
    .rx_irq (rx_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    addr = a; wdata = v; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    chk("wr_ready", {31'd0, ready}, 32'd1);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
    @(negedge clk);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    chk("rd_ready", {31'd0, ready}, 32'd1);
    v = rdata;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int cpb);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (cpb) @(negedge clk);
    end
    uart_rx = stop;
    repeat (cpb) @(negedge clk);
    uart_rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; uart_rx = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_irq", {31'd0, rx_irq}, 32'd0);
    reset = 1'b0;
    bus_read(A_BAUD, d); chk("rst_baud", d, 32'd16);
    bus_read(A_CTRL, d); chk("rst_ctrl", d, 32'd0);
    bus_read(A_ST, d);   chk("rst_status", d, 32'd0);

    // Scenario 1: single byte, interrupt, pop, empty read
    bus_write(A_CTRL, 32'h3);
    send_byte(8'hA5, 1'b1, 16);
    bus_read(A_ST, d); chk("s1_status", d, 32'h1);
    chk("s1_irq", {31'd0, rx_irq}, 32'd1);
    bus_read(A_RX, d); chk("s1_data", d, 32'h0000_00A5);
    @(negedge clk);
    chk("s1_ready_pulse", {31'd0, ready}, 32'd0);
    bus_read(A_ST, d); chk("s1_status_after", d, 32'h0);
    chk("s1_irq_after", {31'd0, rx_irq}, 32'd0);
    bus_read(A_RX, d); chk("s1_empty_read", d, 32'h0);

    // Scenario 2: overrun on the ninth byte
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1, 16);
    bus_read(A_ST, d); chk("s2_status_full_ovr", d, 32'h7);
    for (int i = 1; i <= 8; i++) begin
      bus_read(A_RX, d); chk("s2_data", d, 32'(i));
    end
    bus_read(A_ST, d); chk("s2_status_ovr", d, 32'h4);
    bus_write(A_ST, 32'h4);
    bus_read(A_ST, d); chk("s2_status_clr", d, 32'h0);

    // Scenario 3: framing error then a good byte
    send_byte(8'h3C, 1'b0, 16);
    bus_read(A_ST, d); chk("s3_status_ferr", d, 32'h8);
    send_byte(8'h55, 1'b1, 16);
    bus_read(A_RX, d); chk("s3_data", d, 32'h55);
    bus_write(A_ST, 32'h8);
    bus_read(A_ST, d); chk("s3_status_clr", d, 32'h0);

    // Scenario 4: glitch rejection, then reset mid-frame
    @(negedge clk); uart_rx = 1'b0;
    repeat (3) @(negedge clk); uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(A_ST, d); chk("s4_glitch_status", d, 32'h0);
    send_byte(8'h11, 1'b1, 16);
    bus_read(A_ST, d); chk("s4_pre_status", d, 32'h1);
    chk("s4_pre_irq", {31'd0, rx_irq}, 32'd1);
    @(negedge clk); uart_rx = 1'b0;
    repeat (16) @(negedge clk); uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("s4_rst_rdata", rdata, 32'd0);
    chk("s4_rst_ready", {31'd0, ready}, 32'd0);
    chk("s4_rst_irq", {31'd0, rx_irq}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus_read(A_ST, d);   chk("s4_post_status", d, 32'h0);
    bus_read(A_BAUD, d); chk("s4_post_baud", d, 32'd16);
    bus_read(A_CTRL, d); chk("s4_post_ctrl", d, 32'd0);
    bus_write(A_CTRL, 32'h3);
    send_byte(8'h7E, 1'b1, 16);
    bus_read(A_RX, d); chk("s4_data", d, 32'h7E);

    // Scenario 5: baud clamp and a different bit rate
    bus_write(A_BAUD, 32'd2);
    bus_read(A_BAUD, d); chk("s5_baud_clamp", d, 32'd4);
    bus_write(A_BAUD, 32'd32);
    bus_read(A_BAUD, d); chk("s5_baud32", d, 32'd32);
    send_byte(8'hC3, 1'b1, 32);
    bus_read(A_RX, d); chk("s5_data", d, 32'hC3);
    bus_write(A_BAUD, 32'd16);

    // Scenario 6: read coincides with the stop-bit push into a full FIFO
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b1, 16);
    bus_read(A_ST, d); chk("s6_status_full", d, 32'h3);
    fork
      send_byte(8'h18, 1'b1, 16);
      begin
        repeat (154) @(negedge clk);
        bus_read(A_RX, d); chk("s6_coincident_data", d, 32'h10);
      end
    join
    bus_read(A_ST, d); chk("s6_status_no_ovr", d, 32'h3);
    for (int i = 1; i <= 8; i++) begin
      bus_read(A_RX, d); chk("s6_order", d, 32'h10 + 32'(i));
    end
    bus_read(A_ST, d); chk("s6_status_end", d, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
